// File: rtl/regfile_write_buffer_if.sv
// Bus bundle for regfile_write_buffer: upstream write requests, the register-file
// write port, the bypass query and the occupancy count.
interface regfile_write_buffer_if #(
    parameter int PTR_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_addr;
    logic [31:0]      in_data;
    logic             wrenable;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [4:0]       rd_addr;
    logic             rd_hit;
    logic [31:0]      rd_data;
    logic [PTR_W:0]   count;

    // Upstream pipeline plus register file: drives requests and bypass queries.
    modport master (
        output in_valid, in_addr, in_data, rd_addr,
        input  in_ready, wrenable, wr_addr, wr_data, rd_hit, rd_data, count
    );

    // The write buffer itself.
    modport slave (
        input  in_valid, in_addr, in_data, rd_addr,
        output in_ready, wrenable, wr_addr, wr_data, rd_hit, rd_data, count
    );
endinterface

// File: rtl/regfile_write_buffer.sv
// Circular write buffer in front of the 32x32 register file write port, draining one
// entry per cycle. Forwarding of pending writes is compiled only with REGFILE_WB_BYPASS_EN.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_buffer_if.slave   bus
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [4:0]       addr_q  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic in_ready_c;
    logic push;
    logic pop;

    assign in_ready_c = !reset && (count_q != FULL_COUNT);
    // Register-0 requests complete the handshake but never occupy an entry.
    assign push       = bus.in_valid && in_ready_c && (bus.in_addr != 5'd0);
    // The register file never stalls, so any occupied head is retired every cycle.
    assign pop        = (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: the payload array has no reset; valid_q and count_q alone say which entries mean anything.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.in_addr;
            data_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.count    = count_q;
    assign bus.wrenable = pop;
    assign bus.wr_addr  = pop ? addr_q[rd_ptr_q] : 5'd0;
    assign bus.wr_data  = pop ? data_q[rd_ptr_q] : 32'd0;

`ifdef REGFILE_WB_BYPASS_EN
    logic        rd_hit_c;
    logic [31:0] rd_data_c;

    // Scan oldest to youngest so the last match, the youngest pending write, wins.
    always_comb begin
        rd_hit_c  = 1'b0;
        rd_data_c = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[rd_ptr_q + PTR_W'(k)] &&
                (addr_q[rd_ptr_q + PTR_W'(k)] == bus.rd_addr) &&
                (bus.rd_addr != 5'd0)) begin
                rd_hit_c  = 1'b1;
                rd_data_c = data_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    assign bus.rd_hit  = rd_hit_c;
    assign bus.rd_data = rd_data_c;
`else
    logic unused_bypass;
    assign unused_bypass = ^{bus.rd_addr, valid_q};
    assign bus.rd_hit    = 1'b0;
    assign bus.rd_data   = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer: queue-based reference model compared
// every cycle, plus directed checks with hand-computed values.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;

    regfile_write_buffer_if #(.PTR_W(PTR_W)) bus_if ();

    regfile_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes in acceptance order, index 0 is the oldest.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_push;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_push = bus_if.in_valid && (mq.size() < DEPTH) && (bus_if.in_addr != 5'd0);
            if (mq.size() != 0) void'(mq.pop_front());
            if (m_push) mq.push_back('{addr: bus_if.in_addr, data: bus_if.in_data});
        end
    end

    logic        e_hit;
    logic [31:0] e_rdata;

    always @(negedge clk) begin
        e_hit   = 1'b0;
        e_rdata = 32'd0;
        if (BYP && bus_if.rd_addr != 5'd0) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].addr == bus_if.rd_addr) begin
                    e_hit   = 1'b1;
                    e_rdata = mq[i].data;
                end
            end
        end
        check("m_in_ready", 32'(bus_if.in_ready), 32'(!reset && mq.size() != DEPTH));
        check("m_wrenable", 32'(bus_if.wrenable), 32'(mq.size() != 0));
        check("m_wr_addr",  32'(bus_if.wr_addr),  (mq.size() != 0) ? 32'(mq[0].addr) : 32'd0);
        check("m_wr_data",  bus_if.wr_data,       (mq.size() != 0) ? mq[0].data : 32'd0);
        check("m_count",    32'(bus_if.count),    32'(mq.size()));
        check("m_rd_hit",   32'(bus_if.rd_hit),   32'(e_hit));
        check("m_rd_data",  bus_if.rd_data,       e_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus_if.in_valid = v;
        bus_if.in_addr  = a;
        bus_if.in_data  = d;
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.rd_addr = 5'd0;
        drive(1'b0, 5'd0, 32'd0);
        repeat (2) step();

        check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst_wrenable", 32'(bus_if.wrenable), 32'd0);
        check("rst_rd_hit",   32'(bus_if.rd_hit),   32'd0);
        check("rst_count",    32'(bus_if.count),    32'd0);
        check("rst_wr_addr",  32'(bus_if.wr_addr),  32'd0);
        reset = 1'b0;
        #1;

        // Single push, visible on the write port one cycle after acceptance.
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("sp_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("sp_pre_wren", 32'(bus_if.wrenable), 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("sp_wrenable", 32'(bus_if.wrenable), 32'd1);
        check("sp_wr_addr",  32'(bus_if.wr_addr),  32'd5);
        check("sp_wr_data",  bus_if.wr_data,       32'hDEADBEEF);
        check("sp_count",    32'(bus_if.count),    32'd1);
        step();
        check("sp_drained_wren",  32'(bus_if.wrenable), 32'd0);
        check("sp_drained_count", 32'(bus_if.count),    32'd0);

        // Register 0 is accepted and dropped.
        drive(1'b1, 5'd0, 32'h12345678);
        #1;
        check("r0_in_ready", 32'(bus_if.in_ready), 32'd1);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("r0_count", 32'(bus_if.count),    32'd0);
        check("r0_wren",  32'(bus_if.wrenable), 32'd0);
        step();
        check("r0_wren2", 32'(bus_if.wrenable), 32'd0);

        // Back-to-back pushes: continuous draining holds occupancy at one.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'(100 + i));
            step();
            check("fill_wr_addr",  32'(bus_if.wr_addr),  32'(i));
            check("fill_wr_data",  bus_if.wr_data,       32'(100 + i));
            check("fill_count",    32'(bus_if.count),    32'd1);
            check("fill_in_ready", 32'(bus_if.in_ready), 32'd1);
        end
        drive(1'b0, 5'd0, 32'd0);
        step();
        check("fill_empty", 32'(bus_if.count), 32'd0);

        // Ten entries wrap both pointers more than twice.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'(i));
            step();
            check("wrap_wr_addr", 32'(bus_if.wr_addr), 32'((i % 31) + 1));
            check("wrap_wr_data", bus_if.wr_data,      32'(i));
        end
        drive(1'b0, 5'd0, 32'd0);
        step();
        check("wrap_empty", 32'(bus_if.wrenable), 32'd0);

        // Bypass: a request still on in_* is not forwarded, a queued one is.
        bus_if.rd_addr = 5'd7;
        drive(1'b1, 5'd7, 32'd1);
        #1;
        check("byp_inflight_hit", 32'(bus_if.rd_hit), 32'd0);
        step();
        drive(1'b1, 5'd7, 32'd2);
        #1;
        check("byp_hit1",  32'(bus_if.rd_hit), BYP ? 32'd1 : 32'd0);
        check("byp_data1", bus_if.rd_data,     BYP ? 32'd1 : 32'd0);
        bus_if.rd_addr = 5'd0;
        #1;
        check("byp_r0_hit", 32'(bus_if.rd_hit), 32'd0);
        bus_if.rd_addr = 5'd7;
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("byp_hit2",  32'(bus_if.rd_hit), BYP ? 32'd1 : 32'd0);
        check("byp_data2", bus_if.rd_data,     BYP ? 32'd2 : 32'd0);
        step();
        check("byp_gone_hit",  32'(bus_if.rd_hit), 32'd0);
        check("byp_gone_data", bus_if.rd_data,     32'd0);

        // Asynchronous reset between edges with a write pending.
        drive(1'b1, 5'd9, 32'hAA);
        step();
        drive(1'b1, 5'd10, 32'hBB);
        step();
        drive(1'b0, 5'd0, 32'd0);
        bus_if.rd_addr = 5'd10;
        #1;
        check("mr_pre_hit",   32'(bus_if.rd_hit),   BYP ? 32'd1 : 32'd0);
        check("mr_pre_count", 32'(bus_if.count),    32'd1);
        reset = 1'b1;
        #1;
        check("mr_wrenable", 32'(bus_if.wrenable), 32'd0);
        check("mr_rd_hit",   32'(bus_if.rd_hit),   32'd0);
        check("mr_count",    32'(bus_if.count),    32'd0);
        check("mr_in_ready", 32'(bus_if.in_ready), 32'd0);
        reset = 1'b0;
        step();
        check("mr_after_count", 32'(bus_if.count), 32'd0);
        drive(1'b1, 5'd12, 32'hDD);
        step();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("mr_new_addr", 32'(bus_if.wr_addr), 32'd12);
        check("mr_new_data", bus_if.wr_data,      32'hDD);
        step();
        check("mr_final_count", 32'(bus_if.count), 32'd0);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
